task_dispatch_rs: RTL and testbench
===================================

// Module: task_dispatch_rs
// PURPOSE
//  Parametrised reservation station between the command decoder and NUM_PE Edge PEs.
//  - Buffers decoded task packets.
//  - Issues the oldest task whose SRAM bank is free to an idle PE, out of order w.r.t. blocked tasks.
//  - Supports flush (replay restart) and a drain handshake that signals task completion.
//  - Generalises the fixed 4-PE station to any PE count, bank count, depth and packet width.
// PARAMETERS
//  NUM_PE    4   number of Edge PEs / output channels
//  NUM_BANK  4   number of SRAM banks; BANK_W = $clog2(NUM_BANK)
//  DEPTH     8   station entries (>=2)
//  PKT_W     30  task packet width
// PORTS
//  clk          in   1              clock, rising edge
//  reset        in   1              asynchronous, active-high
//  in_valid     in   1              task offered by decoder
//  in_ready     out  1              station can accept (= ~rs_full)
//  in_packet    in   PKT_W          task payload
//  in_bank      in   BANK_W         bank the task reads
//  flush        in   1              drop all entries and pending state
//  pe_idle      in   NUM_PE         PE p idle
//  bank_busy    in   NUM_BANK       bank b busy; tasks on b are ineligible
//  out_packet   out  NUM_PE*PKT_W   PE p payload in bits [p*PKT_W +: PKT_W]
//  out_valid    out  NUM_PE         1-cycle issue pulse per PE
//  rs_empty     out  1              no valid entries
//  rs_full      out  1              DEPTH valid entries
//  occupancy    out  $clog2(DEPTH)+1  valid entry count
//  drain_req    in   1              level; decoder finished issuing
//  drain_done   out  1              1-cycle completion pulse
// BEHAVIOUR
//  - Reset: all entries invalid, pend=0, out_valid=0, out_packet=0, drain_done=0, rs_empty=1, rs_full=0, occupancy=0.
//  - Storage: collapsing queue; index 0 is oldest; valid entries are contiguous from 0.
//  - Accept: in_valid & in_ready at edge E writes the entry at the tail. in_ready does not depend on same-cycle issue; full means no accept.
//  - PE free: pe_idle[p] & ~pend[p].
//    - pend[p] is set on the edge that issues to p.
//    - pend[p] is cleared on the first edge where pe_idle[p]==0, which blocks re-issue before the PE reacts.
//  - Eligible entry: valid & ~bank_busy[entry.bank].
//  - Select (combinational, registered state): lowest-index eligible entry; at most one issue per cycle. If no PE is free or no entry is eligible, nothing issues.
//  - Issue: at the next edge,
//    - the chosen entry is removed; younger entries shift down one place;
//    - out_packet[p] <= entry.packet and out_valid[p] <= 1 for one cycle; other out_valid bits are 0.
//    - out_packet holds its value between issues.
//  - Latency: a task accepted at edge E can issue at edge E+1 at the earliest; out_valid is then high during the cycle after E+1.
//  - Insert and remove in the same edge: the new entry lands at tail-1 after the collapse; occupancy is unchanged.
//  - Flush has priority over accept and issue. At the edge it:
//    - clears all entries and pend;
//    - forces out_valid=0;
//    - ignores that cycle's in_valid.
//  - Drain: while drain_req=1, drain_done pulses for 1 cycle at the first edge where all of these hold: rs_empty, pe_idle all 1, pend all 0, in_valid=0. It re-arms only after drain_req falls.
//  - Reset mid-operation: async clear to the reset values above; no partial issue.
// CONFIGURATION
//  - DISPATCH_RR_EN defined: round-robin PE choice among free PEs. Pointer starts at 0 and moves to granted+1 (mod NUM_PE) on each issue; flush and reset return it to 0.
//  - DISPATCH_RR_EN undefined: fixed priority, lowest-index free PE; no pointer state.
// STRUCTURE
//  - dispatch_pkg: rs_entry_t {packet[PKT_W-1:0], bank[BANK_W-1:0]}; BANK_W, OCC_W localparams.
//  - Sub-module pe_select (NUM_PE): free vector -> one-hot grant + grant index. Holds the DISPATCH_RR_EN pointer logic.
//  - Top level: collapsing queue, eligibility/oldest-select, pend, drain FSM (IDLE->WAIT->DONE->IDLE).
// TESTING
//  1 Reset, then 3 tasks to bank 0, pe_idle=4'b1111, bank_busy=0
//    -> issues in order on PE0,1,2 (fixed priority), one per cycle; rs_empty after 3rd issue.
//  2 Tasks A(bank1), B(bank2), bank_busy=4'b0010
//    -> B issues first; A issues the cycle after bank_busy[1] falls.
//  3 Fill 8 entries, pe_idle=0
//    -> rs_full=1, in_ready=0, occupancy=8.
//    Then raise pe_idle[3] with in_valid held -> 1 issue on PE3; occupancy stays 8 only if in_ready permits. Check no over-fill.
//  4 Issue to PE0 while pe_idle[0] stays 1 for 3 cycles
//    -> no second issue to PE0 until pe_idle[0] drops and rises again.
//  5 Flush with 5 entries and in_valid=1
//    -> next cycle occupancy=0, out_valid=0, new task dropped; drain_req=1 with PEs idle -> exactly one drain_done pulse.
//  6 DISPATCH_RR_EN, all PEs free, 6 tasks -> PE order 0,1,2,3,0,1.

Source files
------------

// File: rtl/dispatch_pkg.sv
// ----------------------------------------------------------------------------
// dispatch_pkg
// Shared types and constants for the task dispatch reservation station.
//   - DEF_* : default parameter values of the station
//   - clog2_min1() : $clog2 that never returns 0 (for 1- or 2-element indices)
//   - BANK_W / OCC_W : bank index width and occupancy width at the defaults
//   - rs_entry_t : one station entry (payload + bank) at the default sizes
//   - drain_state_e : drain handshake FSM encoding
// ----------------------------------------------------------------------------
package dispatch_pkg;

    localparam int DEF_NUM_PE   = 4;
    localparam int DEF_NUM_BANK = 4;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_PKT_W    = 30;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int BANK_W = clog2_min1(DEF_NUM_BANK);
    localparam int OCC_W  = $clog2(DEF_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_PKT_W-1:0] packet;
        logic [BANK_W-1:0]    bank;
    } rs_entry_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_WAIT = 2'd1,
        DRAIN_DONE = 2'd2
    } drain_state_e;

endpackage

// File: rtl/task_dispatch_rs_pe_select.sv
// ----------------------------------------------------------------------------
// pe_select
// Picks one PE out of a vector of free PEs.
// Build option: DISPATCH_RR_EN
//   defined   : round-robin search starting at an internal pointer; the pointer
//               moves to grant_idx+1 (mod NUM_PE) on every issue, and returns to
//               0 on reset or flush.
//   undefined : fixed priority, lowest-index free PE, no state.
// Ports:
//   clk, rst, flush, advance (RR build only) : pointer clocking and update
//   free      in  NUM_PE  PEs that may accept a task this cycle
//   grant     out NUM_PE  one-hot chosen PE (0 when nothing free)
//   grant_idx out PE_W    index of the chosen PE
//   any_grant out 1       some PE is free
// ----------------------------------------------------------------------------
module pe_select
    import dispatch_pkg::*;
#(
    parameter  int NUM_PE = DEF_NUM_PE,
    localparam int PE_W   = clog2_min1(NUM_PE)
) (
`ifdef DISPATCH_RR_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              advance,
`endif
    input  logic [NUM_PE-1:0] free,
    output logic [NUM_PE-1:0] grant,
    output logic [PE_W-1:0]   grant_idx,
    output logic              any_grant
);

`ifdef DISPATCH_RR_EN
    logic [PE_W-1:0] ptr_q;

    // Search order ptr, ptr+1, ... wrapping; first free PE in that order wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_PE; k++) begin
            idx = (int'(ptr_q) + k) % NUM_PE;
            if (free[idx] && !any_grant) begin
                grant[idx] = 1'b1;
                grant_idx  = PE_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (flush) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == PE_W'(NUM_PE - 1)) ? '0 : grant_idx + PE_W'(1);
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int p = 0; p < NUM_PE; p++) begin
            if (free[p] && !any_grant) begin
                grant[p]  = 1'b1;
                grant_idx = PE_W'(p);
                any_grant = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/task_dispatch_rs.sv
// ----------------------------------------------------------------------------
// task_dispatch_rs
// Reservation station between the command decoder and NUM_PE Edge PEs.
// Buffers decoded tasks in a collapsing queue (index 0 = oldest) and issues
// the oldest task whose SRAM bank is not busy to a free PE, one issue per
// cycle, bypassing tasks that are blocked on a busy bank.
// Build option: DISPATCH_RR_EN selects round-robin PE choice (see pe_select);
// when undefined the lowest-index free PE is used.
//
// Handshake: a task is transferred on a rising edge where in_valid=1 and
// in_ready=1; in_ready is simply ~rs_full and does not look at a same-cycle
// issue. The decoder must hold in_packet/in_bank stable while in_valid=1 and
// in_ready=0. out_valid[p] is a single-cycle pulse with no back-pressure; the
// PE signals acceptance by dropping pe_idle[p].
//
// Ports:
//   clk, reset            clock (rising) and asynchronous active-high reset
//   in_valid/in_ready     task offer / station can accept
//   in_packet, in_bank    task payload and the SRAM bank it reads
//   flush                 drop all entries and pending-issue state
//   pe_idle               per-PE idle indication
//   bank_busy             per-bank busy; tasks on a busy bank are skipped
//   out_packet, out_valid per-PE payload (held between issues) and issue pulse
//   rs_empty, rs_full     no entries / DEPTH entries
//   occupancy             number of valid entries
//   drain_req, drain_done drain request level and 1-cycle completion pulse
//   drain_state           current drain FSM state (observability)
// ----------------------------------------------------------------------------
module task_dispatch_rs
    import dispatch_pkg::*;
#(
    parameter  int NUM_PE    = DEF_NUM_PE,
    parameter  int NUM_BANK  = DEF_NUM_BANK,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int PKT_W     = DEF_PKT_W,
    localparam int BANK_BITS = clog2_min1(NUM_BANK),
    localparam int OCC_BITS  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PKT_W-1:0]        in_packet,
    input  logic [BANK_BITS-1:0]    in_bank,
    input  logic                    flush,
    input  logic [NUM_PE-1:0]       pe_idle,
    input  logic [NUM_BANK-1:0]     bank_busy,
    output logic [NUM_PE*PKT_W-1:0] out_packet,
    output logic [NUM_PE-1:0]       out_valid,
    output logic                    rs_empty,
    output logic                    rs_full,
    output logic [OCC_BITS-1:0]     occupancy,
    input  logic                    drain_req,
    output logic                    drain_done,
    output logic [1:0]              drain_state
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PE_BITS = clog2_min1(NUM_PE);

    // Queue storage; entries at index >= count_q are don't-care.
    logic [PKT_W-1:0]     pkt_q  [DEPTH];
    logic [BANK_BITS-1:0] bank_q [DEPTH];
    logic [PKT_W-1:0]     pkt_d  [DEPTH];
    logic [BANK_BITS-1:0] bank_d [DEPTH];

    logic [OCC_BITS-1:0] count_q, count_d, wr_idx;
    logic [NUM_PE-1:0]   pend_q, pend_d, free, grant;
    logic [PE_BITS-1:0]  grant_idx;
    logic                any_grant;
    logic [DEPTH-1:0]    eligible;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_found;
    logic                accept, issue;

    drain_state_e        drain_st, drain_nxt;
    logic                drain_fire, drain_cond;

    assign rs_empty    = (count_q == '0);
    assign rs_full     = (count_q == OCC_BITS'(DEPTH));
    assign in_ready    = ~rs_full;
    assign occupancy   = count_q;
    assign drain_state = drain_st;

    // A PE that was just issued to stays blocked until it shows busy once,
    // so a PE that is slow to drop pe_idle is not handed a second task.
    assign free = pe_idle & ~pend_q;

    // ---------------- eligibility and oldest-first select ----------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = (OCC_BITS'(i) < count_q) && !bank_busy[bank_q[i]];
        end
    end

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (eligible[i] && !sel_found) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    pe_select #(
        .NUM_PE    (NUM_PE)
    ) u_pe_select (
`ifdef DISPATCH_RR_EN
        .clk       (clk),
        .rst       (reset),
        .flush     (flush),
        .advance   (issue),
`endif
        .free      (free),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Flush wins over both accept and issue.
    assign accept = in_valid & in_ready & ~flush;
    assign issue  = sel_found & any_grant & ~flush;

    // ---------------- collapsing queue next state ----------------
    // The tail slot is computed after the removal, so a simultaneous
    // insert+remove lands at the old tail-1 and occupancy is unchanged.
    assign wr_idx = count_q - OCC_BITS'(issue);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pkt_d[i]  = pkt_q[i];
            bank_d[i] = bank_q[i];
        end
        if (issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    pkt_d[i]  = pkt_q[i+1];
                    bank_d[i] = bank_q[i+1];
                end
            end
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (OCC_BITS'(i) == wr_idx) begin
                    pkt_d[i]  = in_packet;
                    bank_d[i] = in_bank;
                end
            end
        end
    end

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + OCC_BITS'(accept) - OCC_BITS'(issue);
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int p = 0; p < NUM_PE; p++) begin
            if (flush) begin
                pend_d[p] = 1'b0;
            end else if (issue && grant[p]) begin
                pend_d[p] = 1'b1;
            end else if (!pe_idle[p]) begin
                pend_d[p] = 1'b0;
            end
        end
    end

    // Payload storage needs no reset: validity is carried by count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            pkt_q[i]  <= pkt_d[i];
            bank_q[i] <= bank_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            pend_q     <= '0;
            out_valid  <= '0;
            out_packet <= '0;
        end else begin
            count_q   <= count_d;
            pend_q    <= pend_d;
            out_valid <= issue ? grant : '0;
            if (issue) begin
                out_packet[int'(grant_idx)*PKT_W +: PKT_W] <= pkt_q[sel_idx];
            end
        end
    end

    // ---------------- drain handshake ----------------
    // DONE is held until drain_req falls so one request yields one pulse.
    assign drain_cond = rs_empty & (&pe_idle) & ~(|pend_q) & ~in_valid;

    always_comb begin
        drain_nxt  = drain_st;
        drain_fire = 1'b0;
        case (drain_st)
            DRAIN_IDLE: begin
                if (drain_req) begin
                    if (drain_cond) begin
                        drain_nxt  = DRAIN_DONE;
                        drain_fire = 1'b1;
                    end else begin
                        drain_nxt = DRAIN_WAIT;
                    end
                end
            end
            DRAIN_WAIT: begin
                if (!drain_req) begin
                    drain_nxt = DRAIN_IDLE;
                end else if (drain_cond) begin
                    drain_nxt  = DRAIN_DONE;
                    drain_fire = 1'b1;
                end
            end
            DRAIN_DONE: begin
                if (!drain_req) begin
                    drain_nxt = DRAIN_IDLE;
                end
            end
            default: drain_nxt = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_st   <= DRAIN_IDLE;
            drain_done <= 1'b0;
        end else begin
            drain_st   <= drain_nxt;
            drain_done <= drain_fire;
        end
    end

endmodule

// File: tb/tb_task_dispatch_rs.sv
// ----------------------------------------------------------------------------
// tb_task_dispatch_rs
// Directed bench for task_dispatch_rs. Each expected issue {pe, packet} is
// queued before the stimulus that causes it; an independent monitor pops and
// compares on every out_valid pulse. Status outputs are checked inline.
// Works in both the fixed-priority and DISPATCH_RR_EN builds.
// ----------------------------------------------------------------------------
module tb_task_dispatch_rs;

    localparam int NUM_PE   = 4;
    localparam int NUM_BANK = 4;
    localparam int DEPTH    = 8;
    localparam int PKT_W    = 30;
    localparam int W        = PKT_W + 2;
`ifdef DISPATCH_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                    in_valid;
    logic                    in_ready;
    logic [PKT_W-1:0]        in_packet;
    logic [1:0]              in_bank;
    logic                    flush;
    logic [NUM_PE-1:0]       pe_idle;
    logic [NUM_BANK-1:0]     bank_busy;
    logic [NUM_PE*PKT_W-1:0] out_packet;
    logic [NUM_PE-1:0]       out_valid;
    logic                    rs_empty;
    logic                    rs_full;
    logic [3:0]              occupancy;
    logic                    drain_req;
    logic                    drain_done;
    logic [1:0]              drain_state;

    task_dispatch_rs #(
        .NUM_PE      (NUM_PE),
        .NUM_BANK    (NUM_BANK),
        .DEPTH       (DEPTH),
        .PKT_W       (PKT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_packet   (in_packet),
        .in_bank     (in_bank),
        .flush       (flush),
        .pe_idle     (pe_idle),
        .bank_busy   (bank_busy),
        .out_packet  (out_packet),
        .out_valid   (out_valid),
        .rs_empty    (rs_empty),
        .rs_full     (rs_full),
        .occupancy   (occupancy),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .drain_state (drain_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] mon_got, mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic exp_push(input int pe, input logic [PKT_W-1:0] pkt);
        exp_q.push_back({2'(pe), pkt});
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid != '0) begin
            n_checks++;
            if ($countones(out_valid) == 1) n_pass++;
            else $display("FAIL issue_onehot: out_valid=0b%b, expected one bit", out_valid);
            for (int p = 0; p < NUM_PE; p++) begin
                if (out_valid[p]) begin
                    mon_got = {2'(p), out_packet[p*PKT_W +: PKT_W]};
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL issue: unexpected issue pe%0d pkt 0x%0h", p,
                                 out_packet[p*PKT_W +: PKT_W]);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_got === mon_exp) n_pass++;
                        else $display("FAIL issue: got pe%0d pkt 0x%0h, expected pe%0d pkt 0x%0h",
                                      mon_got[W-1 -: 2], mon_got[PKT_W-1:0],
                                      mon_exp[W-1 -: 2], mon_exp[PKT_W-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [PKT_W-1:0] pkt, input logic [1:0] bank);
        in_valid  = 1'b1;
        in_packet = pkt;
        in_bank   = bank;
        step(1);
        in_valid  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_packet = '0;
        in_bank   = '0;
        flush     = 1'b0;
        pe_idle   = '0;
        bank_busy = '0;
        drain_req = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset values
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_empty", 32'(rs_empty), 32'd1);
        chk("rst_full", 32'(rs_full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_packet_lo", out_packet[31:0], 32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);

        // 1: three tasks, all PEs idle -> PE0, PE1, PE2 in order
        pe_idle = 4'b1111;
        exp_push(0, 30'h1000_0001);
        exp_push(1, 30'h1000_0002);
        exp_push(2, 30'h1000_0003);
        push(30'h1000_0001, 2'd0);
        push(30'h1000_0002, 2'd0);
        push(30'h1000_0003, 2'd0);
        step(2);
        chk("t1_empty", 32'(rs_empty), 32'd1);
        chk("t1_occupancy", 32'(occupancy), 32'd0);
        pe_idle = 4'b0000;
        step(1);

        // 2: A on busy bank1 is bypassed by B on bank2
        bank_busy = 4'b0010;
        pe_idle   = 4'b1111;
        exp_push(RR ? 3 : 0, 30'h2000_000B);
        exp_push(RR ? 0 : 1, 30'h2000_000A);
        push(30'h2000_000A, 2'd1);
        push(30'h2000_000B, 2'd2);
        step(3);
        chk("t2_blocked_occ", 32'(occupancy), 32'd1);
        bank_busy = 4'b0000;
        step(2);
        chk("t2_final_occ", 32'(occupancy), 32'd0);
        pe_idle = 4'b0000;
        step(1);

        // 3: fill to DEPTH with PEs busy, then free PE3 with in_valid held
        for (int i = 0; i < DEPTH; i++) begin
            push(PKT_W'(32'h0300_0000 + i), 2'(i % 4));
        end
        chk("t3_full", 32'(rs_full), 32'd1);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_occupancy", 32'(occupancy), 32'd8);
        exp_push(3, 30'h0300_0000);
        in_valid  = 1'b1;
        in_packet = 30'h0300_0099;
        in_bank   = 2'd0;
        pe_idle   = 4'b1000;
        step(2);
        in_valid  = 1'b0;
        chk("t3_refill_occ", 32'(occupancy), 32'd8);
        step(2);
        chk("t3_no_overfill", 32'(occupancy), 32'd8);
        chk("t3_full_again", 32'(rs_full), 32'd1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("t3_flush_occ", 32'(occupancy), 32'd0);

        // 4: PE0 stays idle after issue -> no re-issue until it toggles
        pe_idle = 4'b0001;
        exp_push(0, 30'h0400_0001);
        exp_push(0, 30'h0400_0002);
        push(30'h0400_0001, 2'd0);
        push(30'h0400_0002, 2'd0);
        step(4);
        chk("t4_held_occ", 32'(occupancy), 32'd1);
        pe_idle = 4'b0000;
        step(1);
        chk("t4_toggle_occ", 32'(occupancy), 32'd1);
        pe_idle = 4'b0001;
        step(2);
        chk("t4_reissue_occ", 32'(occupancy), 32'd0);

        // 5: flush with 5 entries and in_valid high, then drain
        pe_idle = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            push(PKT_W'(32'h0500_0000 + i), 2'(i % 4));
        end
        chk("t5_occ5", 32'(occupancy), 32'd5);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_packet = 30'h0500_00FF;
        in_bank   = 2'd0;
        step(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_flush_occ", 32'(occupancy), 32'd0);
        chk("t5_flush_valid", 32'(out_valid), 32'd0);
        chk("t5_flush_empty", 32'(rs_empty), 32'd1);
        step(1);
        chk("t5_dropped", 32'(occupancy), 32'd0);
        pe_idle   = 4'b1111;
        drain_req = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (drain_done) pulses++;
        end
        chk("t5_drain_pulses", 32'(pulses), 32'd1);
        drain_req = 1'b0;
        step(1);
        chk("t5_drain_low", 32'(drain_done), 32'd0);

        // 6: six tasks, all PEs freed between issues
        for (int k = 0; k < 6; k++) begin
            exp_push(RR ? (k % 4) : 0, PKT_W'(32'h0600_0000 + k));
        end
        for (int k = 0; k < 6; k++) begin
            pe_idle = 4'b1111;
            push(PKT_W'(32'h0600_0000 + k), 2'(k % 4));
            step(2);
            pe_idle = 4'b0000;
            step(1);
        end

        step(3);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
